// File: rtl/sobel_ctrl_pkg.sv
// Shared types for the Sobel frame controller: FSM state encoding and pixel channel width.
package sobel_ctrl_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN
  } state_t;

endpackage

// File: rtl/sobel_ctrl_counter.sv
// Up-counter with synchronous clear/enable and a terminal-count compare; 0-cycle compare latency.
// No backpressure: counts whenever en_i is high, clear wins over enable.
module sobel_ctrl_counter #(
  parameter int CNT_W  = 4,
  parameter int TERM_P = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM_P);

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

  assign term_o = (cnt_o == TERM_C);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around the Sobel pipeline: clear, feed, flush, drain; SOBEL_CTRL_TIMEOUT_EN adds a drain watchdog.
// Latency: source->pipe 1 cycle registered, pipe->sink 1 cycle registered; done_o one cycle after out_last_o.
// Backpressure: in_ready_o only in FEED; pipeline and sink never stall.
module sobel_frame_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int WIDTH_P    = 10,
  parameter int HEIGHT_P   = 10,
  parameter int CHANNELS_P = 1,
  parameter int FLUSH_P    = WIDTH_P + 1,
  parameter int SKIP_P     = WIDTH_P + 1,
  parameter int TIMEOUT_P  = 1024
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [CHANNELS_P*PIX_W-1:0] in_pixel_i,
  output logic                        pipe_reset_o,
  output logic                        pipe_valid_o,
  output logic [CHANNELS_P*PIX_W-1:0] pipe_pixel_o,
  input  logic                        pipe_valid_i,
  input  logic [CHANNELS_P*PIX_W-1:0] pipe_pixel_i,
  output logic                        out_valid_o,
  output logic [CHANNELS_P*PIX_W-1:0] out_pixel_o,
  output logic                        out_last_o,
  output logic                        error_o
);

  localparam int NPIX  = WIDTH_P * HEIGHT_P;
  localparam int IN_W  = $clog2(NPIX + 1);
  localparam int FL_W  = (FLUSH_P > 0) ? $clog2(FLUSH_P + 1) : 1;
  localparam int OUT_W = $clog2(SKIP_P + NPIX + 1);

  localparam logic [OUT_W-1:0] FIRST_C = OUT_W'(SKIP_P);
  localparam logic [OUT_W-1:0] FINAL_C = OUT_W'(SKIP_P + NPIX - 1);
  localparam logic [OUT_W-1:0] SAT_C   = OUT_W'(SKIP_P + NPIX);

  state_t state_q, state_d;

  logic             hs, in_term, fl_term, out_term;
  logic             cnt_act, fwd, last_fwd;
  logic             out_done_q, done_d, err_set, timeout;
  logic [IN_W-1:0]  in_cnt;
  logic [FL_W-1:0]  fl_cnt;
  logic [OUT_W-1:0] out_cnt;

  assign in_ready_o   = (state_q == FEED);
  assign hs           = in_valid_i & in_ready_o;
  assign busy_o       = (state_q != IDLE);
  assign pipe_reset_o = reset_i | (state_q == CLEAR);
  assign cnt_act      = state_q inside {FEED, FLUSH, DRAIN};

  // Only the window [SKIP_P, SKIP_P+NPIX) of pipeline outputs belongs to the frame.
  assign fwd      = cnt_act & pipe_valid_i & (out_cnt >= FIRST_C) & (out_cnt <= FINAL_C);
  assign last_fwd = fwd & out_term;

  sobel_ctrl_counter #(.CNT_W(IN_W), .TERM_P(NPIX - 1)) u_in_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (state_q == CLEAR),
    .en_i   (hs),
    .cnt_o  (in_cnt),
    .term_o (in_term)
  );

  sobel_ctrl_counter #(.CNT_W(FL_W), .TERM_P((FLUSH_P > 0) ? FLUSH_P - 1 : 0)) u_fl_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (state_q == CLEAR),
    .en_i   (state_q == FLUSH),
    .cnt_o  (fl_cnt),
    .term_o (fl_term)
  );

  // Saturates one past the last frame output so surplus outputs never wrap back into the window.
  sobel_ctrl_counter #(.CNT_W(OUT_W), .TERM_P(SKIP_P + NPIX - 1)) u_out_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (state_q == CLEAR),
    .en_i   (cnt_act & pipe_valid_i & (out_cnt != SAT_C)),
    .cnt_o  (out_cnt),
    .term_o (out_term)
  );

`ifdef SOBEL_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_P + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_term;
  logic            error_q;
  logic            unused_ok;

  sobel_ctrl_counter #(.CNT_W(WD_W), .TERM_P(TIMEOUT_P - 1)) u_wd_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  ((state_q != DRAIN) | pipe_valid_i),
    .en_i   ((state_q == DRAIN) & ~pipe_valid_i),
    .cnt_o  (wd_cnt),
    .term_o (wd_term)
  );

  assign timeout = (state_q == DRAIN) & ~pipe_valid_i & wd_term;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_q <= 1'b0;
    end else if ((state_q == IDLE) && start_i) begin
      error_q <= 1'b0;
    end else if (err_set) begin
      error_q <= 1'b1;
    end
  end

  assign error_o   = error_q;
  assign unused_ok = ^{in_cnt, fl_cnt, wd_cnt};
`else
  logic unused_ok;

  assign timeout   = 1'b0;
  assign error_o   = 1'b0;
  assign unused_ok = ^{in_cnt, fl_cnt, err_set, TIMEOUT_P};
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE:  if (start_i) state_d = CLEAR;
      CLEAR: state_d = FEED;
      FEED:  if (hs && in_term) state_d = (FLUSH_P > 0) ? FLUSH : DRAIN;
      FLUSH: if (fl_term) state_d = DRAIN;
      DRAIN: begin
        if (out_done_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timeout) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pipe_valid_o <= 1'b0;
      pipe_pixel_o <= '0;
      out_valid_o  <= 1'b0;
      out_pixel_o  <= '0;
      out_last_o   <= 1'b0;
      done_o       <= 1'b0;
      out_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pipe_valid_o <= hs | (state_q == FLUSH);
      pipe_pixel_o <= hs ? in_pixel_i : '0;
      out_valid_o  <= fwd;
      out_pixel_o  <= fwd ? pipe_pixel_i : '0;
      out_last_o   <= last_fwd;
      done_o       <= done_d;
      // Registered completion lets DRAIN exit a cycle after out_last_o's source, keeping done_o one behind it.
      if (state_q == CLEAR) begin
        out_done_q <= 1'b0;
      end else if (last_fwd) begin
        out_done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Randomized frame-level bench for sobel_frame_ctrl with a 3-cycle delay-line pipeline model.
module tb_sobel_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NP = W * H;
  localparam int FL = 5;
  localparam int SK = 5;
  localparam int TO = 8;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset_i, start_i, in_valid_i;
  logic [7:0] in_pixel_i;
  logic       busy_o, done_o, in_ready_o, pipe_reset_o, pipe_valid_o;
  logic [7:0] pipe_pixel_o;
  logic       pipe_valid_i;
  logic [7:0] pipe_pixel_i;
  logic       out_valid_o, out_last_o, error_o;
  logic [7:0] out_pixel_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .WIDTH_P(W), .HEIGHT_P(H), .CHANNELS_P(1), .FLUSH_P(FL), .SKIP_P(SK), .TIMEOUT_P(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pixel_i(in_pixel_i),
    .pipe_reset_o(pipe_reset_o), .pipe_valid_o(pipe_valid_o), .pipe_pixel_o(pipe_pixel_o),
    .pipe_valid_i(pipe_valid_i), .pipe_pixel_i(pipe_pixel_i),
    .out_valid_o(out_valid_o), .out_pixel_o(out_pixel_o), .out_last_o(out_last_o),
    .error_o(error_o)
  );

  // Pipeline stand-in: fixed 3-cycle delay, output = input ^ 0x5A, optional cap on outputs emitted.
  logic [2:0] sv;
  logic [7:0] sp0, sp1, sp2;
  int         emitted;
  int         emit_limit = 1000;

  always @(posedge clk) begin
    if (pipe_reset_o) begin
      sv      <= '0;
      emitted <= 0;
    end else begin
      sv  <= {sv[1:0], pipe_valid_o};
      sp0 <= pipe_pixel_o;
      sp1 <= sp0;
      sp2 <= sp1;
      if (pipe_valid_i) emitted <= emitted + 1;
    end
  end

  assign pipe_valid_i = sv[2] && (emitted < emit_limit);
  assign pipe_pixel_i = pipe_valid_i ? (sp2 ^ 8'h5A) : 8'h00;

  // Monitor
  int  cyc = 0;
  int  n_clear, n_done, n_last, last_idx, last_cyc, done_cyc, err_cyc, last_pv_cyc;
  bq_t pipe_q, out_q;

  always @(negedge clk) begin
    cyc++;
    if (pipe_reset_o && !reset_i) n_clear++;
    if (pipe_valid_o) begin
      pipe_q.push_back(pipe_pixel_o);
      last_pv_cyc = cyc;
    end
    if (out_valid_o) begin
      out_q.push_back(out_pixel_o);
      if (out_last_o) begin
        n_last++;
        last_idx = out_q.size();
        last_cyc = cyc;
      end
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (error_o && err_cyc < 0) err_cyc = cyc;
  end

  function automatic bq_t rand_pix();
    bq_t r;
    for (int k = 0; k < NP; k++) r.push_back(8'($urandom_range(1, 255)));
    return r;
  endfunction

  // Pipeline input stream: the frame followed by FL zero pixels.
  function automatic bq_t model_stream(input bq_t pix);
    bq_t r;
    for (int k = 0; k < NP + FL; k++) r.push_back(k < NP ? pix[k] : 8'h00);
    return r;
  endfunction

  // Forwarded outputs: pipeline outputs SK..SK+NP-1 of the model.
  function automatic bq_t model_out(input bq_t pix);
    bq_t s = model_stream(pix);
    bq_t r;
    for (int k = 0; k < NP; k++) r.push_back(s[SK + k] ^ 8'h5A);
    return r;
  endfunction

  task automatic clear_mon();
    n_clear = 0; n_done = 0; n_last = 0; last_idx = -1;
    last_cyc = -100; done_cyc = -200; err_cyc = -1; last_pv_cyc = -300;
    pipe_q.delete();
    out_q.delete();
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    clear_mon();
  endtask

  task automatic feed(input bq_t pix, input bit gaps, input int busy_at, input int stop_after);
    int i = 0;
    int guard = 0;
    bit tog = 1'b1;
    bit pulsed = 1'b0;
    bit hs;
    while (i < stop_after && guard < 300) begin
      in_valid_i = gaps ? tog : 1'b1;
      in_pixel_i = pix[i];
      start_i    = (i == busy_at) && !pulsed;
      if (start_i) pulsed = 1'b1;
      hs = in_valid_i && in_ready_o;
      @(posedge clk); #1;
      if (hs) i++;
      tog = !tog;
      guard++;
    end
    in_valid_i = 1'b0;
    in_pixel_i = 8'h00;
    start_i    = 1'b0;
    checks++;
    if (i != stop_after) begin
      failures++;
      $display("FAIL feed_accept accepted=%0d required=%0d", i, stop_after);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done_o) begin
      failures++;
      $display("FAIL wait_done no done_o within %0d cycles", n);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b1; in_valid_i = 1'b1; in_pixel_i = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, in_ready_o, pipe_valid_o, pipe_pixel_o, out_valid_o, out_pixel_o,
         out_last_o, error_o, pipe_reset_o} !== {24'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b rdy=%b pv=%b pp=%h ov=%b op=%h last=%b err=%b prst=%b required all 0, prst=1",
               busy_o, done_o, in_ready_o, pipe_valid_o, pipe_pixel_o, out_valid_o, out_pixel_o,
               out_last_o, error_o, pipe_reset_o);
    end
    reset_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; in_pixel_i = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || pipe_reset_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b prst=%b required 0 0", busy_o, pipe_reset_o);
    end
  endtask

  task automatic test_nominal();
    bq_t pix, exp_s, exp_o;
    int bad;
    for (int k = 0; k < NP; k++) pix.push_back(8'(k + 1));
    exp_s = model_stream(pix);
    exp_o = model_out(pix);
    start_frame();
    feed(pix, 1'b0, -1, NP);
    wait_done();
    checks++;
    if (n_clear != 1) begin failures++; $display("FAIL nominal_clear got=%0d required=1", n_clear); end
    checks++;
    bad = 0;
    for (int k = 0; k < NP + FL; k++) if (k >= pipe_q.size() || pipe_q[k] !== exp_s[k]) bad++;
    if (bad != 0 || pipe_q.size() != NP + FL) begin
      failures++;
      $display("FAIL nominal_pipe_stream len=%0d bad=%0d required len=%0d bad=0", pipe_q.size(), bad, NP + FL);
    end
    checks++;
    if (out_q.size() != NP) begin failures++; $display("FAIL nominal_out_count got=%0d required=%0d", out_q.size(), NP); end
    checks++;
    bad = 0;
    for (int k = 0; k < NP; k++) if (k >= out_q.size() || out_q[k] !== exp_o[k]) bad++;
    if (bad != 0) begin failures++; $display("FAIL nominal_out_data bad=%0d required=0", bad); end
    checks++;
    if (n_last != 1 || last_idx != NP) begin
      failures++;
      $display("FAIL nominal_last count=%0d index=%0d required 1 %0d", n_last, last_idx, NP);
    end
    checks++;
    if (n_done != 1 || done_cyc - last_cyc != 1) begin
      failures++;
      $display("FAIL nominal_done_timing count=%0d offset=%0d required 1 1", n_done, done_cyc - last_cyc);
    end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL nominal_busy_after got=%b required=0", busy_o); end
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0 || error_o !== 1'b0) begin
      failures++;
      $display("FAIL nominal_done_pulse done=%b err=%b required 0 0", done_o, error_o);
    end
  endtask

  task automatic test_gaps();
    bq_t pix = rand_pix();
    bq_t exp_s = model_stream(pix);
    bq_t exp_o = model_out(pix);
    int bad = 0;
    start_frame();
    feed(pix, 1'b1, -1, NP);
    wait_done();
    checks++;
    for (int k = 0; k < NP + FL; k++) if (k >= pipe_q.size() || pipe_q[k] !== exp_s[k]) bad++;
    if (bad != 0 || pipe_q.size() != NP + FL) begin
      failures++;
      $display("FAIL gaps_pipe_stream len=%0d bad=%0d required len=%0d bad=0", pipe_q.size(), bad, NP + FL);
    end
    checks++;
    bad = 0;
    for (int k = 0; k < NP; k++) if (k >= out_q.size() || out_q[k] !== exp_o[k]) bad++;
    if (bad != 0 || out_q.size() != NP) begin
      failures++;
      $display("FAIL gaps_out len=%0d bad=%0d required len=%0d bad=0", out_q.size(), bad, NP);
    end
    checks++;
    if (n_last != 1 || last_idx != NP || done_cyc - last_cyc != 1) begin
      failures++;
      $display("FAIL gaps_last count=%0d index=%0d done_offset=%0d required 1 %0d 1",
               n_last, last_idx, done_cyc - last_cyc, NP);
    end
  endtask

  task automatic test_start_busy();
    bq_t pix = rand_pix();
    bq_t exp_o = model_out(pix);
    int bad = 0;
    start_frame();
    feed(pix, 1'b0, 5, NP);
    wait_done();
    checks++;
    if (n_clear != 1) begin failures++; $display("FAIL busy_start_clear got=%0d required=1", n_clear); end
    checks++;
    for (int k = 0; k < NP; k++) if (k >= out_q.size() || out_q[k] !== exp_o[k]) bad++;
    if (bad != 0 || out_q.size() != NP || n_last != 1) begin
      failures++;
      $display("FAIL busy_start_out len=%0d bad=%0d last=%0d required len=%0d bad=0 last=1",
               out_q.size(), bad, n_last, NP);
    end
  endtask

  task automatic test_reset_mid();
    bq_t pix = rand_pix();
    bq_t pix2 = rand_pix();
    bq_t exp_o = model_out(pix2);
    int bad = 0;
    start_frame();
    feed(pix, 1'b0, -1, 7);
    reset_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_o, done_o, in_ready_o, pipe_valid_o, pipe_pixel_o, out_valid_o, out_pixel_o,
         out_last_o, error_o, pipe_reset_o} !== {24'h0, 1'b1}) begin
      failures++;
      $display("FAIL midreset_outputs busy=%b rdy=%b pv=%b pp=%h ov=%b op=%h prst=%b required all 0, prst=1",
               busy_o, in_ready_o, pipe_valid_o, pipe_pixel_o, out_valid_o, out_pixel_o, pipe_reset_o);
    end
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle busy=%b rdy=%b ov=%b required 0 0 0", busy_o, in_ready_o, out_valid_o);
    end
    start_frame();
    feed(pix2, 1'b0, -1, NP);
    wait_done();
    checks++;
    for (int k = 0; k < NP; k++) if (k >= out_q.size() || out_q[k] !== exp_o[k]) bad++;
    if (bad != 0 || out_q.size() != NP || n_last != 1 || last_idx != NP) begin
      failures++;
      $display("FAIL midreset_refill len=%0d bad=%0d last=%0d idx=%0d required len=%0d bad=0 last=1 idx=%0d",
               out_q.size(), bad, n_last, last_idx, NP, NP);
    end
  endtask

  task automatic test_back_to_back();
    bq_t pa = rand_pix();
    bq_t pb = rand_pix();
    bq_t ea = model_out(pa);
    bq_t eb = model_out(pb);
    int bad = 0;
    start_frame();
    feed(pa, 1'b0, -1, NP);
    wait_done();
    checks++;
    for (int k = 0; k < NP; k++) if (k >= out_q.size() || out_q[k] !== ea[k]) bad++;
    if (bad != 0 || out_q.size() != NP) begin
      failures++;
      $display("FAIL b2b_first len=%0d bad=%0d required len=%0d bad=0", out_q.size(), bad, NP);
    end
    start_frame();
    feed(pb, 1'b0, -1, NP);
    wait_done();
    checks++;
    if (n_clear != 1) begin failures++; $display("FAIL b2b_clear got=%0d required=1", n_clear); end
    checks++;
    bad = 0;
    for (int k = 0; k < NP; k++) if (k >= out_q.size() || out_q[k] !== eb[k]) bad++;
    if (bad != 0 || out_q.size() != NP || n_last != 1 || done_cyc - last_cyc != 1) begin
      failures++;
      $display("FAIL b2b_second len=%0d bad=%0d last=%0d done_offset=%0d required len=%0d bad=0 last=1 offset=1",
               out_q.size(), bad, n_last, done_cyc - last_cyc, NP);
    end
  endtask

`ifdef SOBEL_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    bq_t pix = rand_pix();
    emit_limit = 4;
    start_frame();
    feed(pix, 1'b0, -1, NP);
    wait_done();
    checks++;
    if (err_cyc - last_pv_cyc != TO || done_cyc != err_cyc) begin
      failures++;
      $display("FAIL timeout_timing err_offset=%0d done_minus_err=%0d required %0d 0",
               err_cyc - last_pv_cyc, done_cyc - err_cyc, TO);
    end
    checks++;
    if (n_last != 0 || out_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_no_last last=%0d outs=%0d required 0 0", n_last, out_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (error_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_sticky err=%b busy=%b required 1 0", error_o, busy_o);
    end
    emit_limit = 1000;
    start_frame();
    checks++;
    if (error_o !== 1'b0) begin failures++; $display("FAIL timeout_clear_on_start err=%b required=0", error_o); end
    feed(pix, 1'b0, -1, NP);
    wait_done();
    checks++;
    if (out_q.size() != NP || n_last != 1 || error_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_recover outs=%0d last=%0d err=%b required %0d 1 0", out_q.size(), n_last, error_o, NP);
    end
  endtask
`endif

  initial begin
    reset_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_pixel_i = 8'h00;
    clear_mon();
    test_reset();
    test_nominal();
    test_gaps();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef SOBEL_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
